// File: rtl/ogfx_sync_req_tx.sv
// ---------------------------------------------------------------------------
// ogfx_sync_req_tx
//
// Source side of a four-phase req/ack clock-domain-crossing handshake.
// A word handed in with `send` is presented on `data_out` and announced
// by raising `req_out`. The destination answers by raising `ack_in`.
// The source then drops `req_out`, and the transfer completes when
// `ack_in` falls again. A one-deep pending slot absorbs a second word that
// arrives while a transfer is in flight. A timeout counter abandons a
// handshake that the far side never answers.
//
// Parameters
//   DW       data word width in bits
//   TMO_W    width of the handshake timeout counter; the timeout fires
//            when the counter reaches 2**TMO_W-1 (must be >= 2)
//
// Ports
//   clk       in   single clock, rising-edge
//   rst       in   synchronous active-high reset
//   send      in   one-cycle request to transfer data_in
//   data_in   in   [DW] word sampled when send=1
//   ack_in    in   destination acknowledge, already synchronized into clk
//   req_out   out  four-phase request level toward the destination
//   data_out  out  [DW] transfer word, stable while req_out=1
//   busy      out  handshake in progress or pending slot occupied
//   done      out  one-cycle pulse: handshake completed (ack_in fell)
//   overflow  out  one-cycle pulse: send dropped because the slot was full
//   timeout   out  one-cycle pulse: handshake abandoned
// ---------------------------------------------------------------------------
module ogfx_sync_req_tx #(
    parameter int DW    = 16,
    parameter int TMO_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic [DW-1:0] data_in,
    input  logic          ack_in,
    output logic          req_out,
    output logic [DW-1:0] data_out,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Last count before the terminal value 2**TMO_W-1. The timeout fires on
    // the edge where the counter would step onto the terminal value. That
    // edge is also a state change, so the counter clears and never wraps.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             pend_vld;
    logic [DW-1:0]    pend_data;
    logic [TMO_W-1:0] tmo_cnt;

    logic             launch_direct;  // data_in goes straight to data_out
    logic             launch_pend;    // pending word goes to data_out, slot drains
    logic             done_nxt;
    logic             tmo_hit;
    logic             slot_free;
    logic             store_send;
    logic             drop_send;

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case;
        // otherwise any path that skips an assignment infers a latch.
        state_nxt     = state;
        launch_direct = 1'b0;
        launch_pend   = 1'b0;
        done_nxt      = 1'b0;
        tmo_hit       = 1'b0;

        case (state)
            ST_IDLE: begin
                // A stale ack from the previous handshake must be gone
                // before a new request is raised. The pending word is older
                // than any send arriving now, so it goes first.
                if (!ack_in) begin
                    if (pend_vld) begin
                        launch_pend = 1'b1;
                        state_nxt   = ST_REQ;
                    end else if (send) begin
                        launch_direct = 1'b1;
                        state_nxt     = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                // Handshake progress wins over a timeout on the same cycle.
                if (ack_in) begin
                    state_nxt = ST_RELEASE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            ST_RELEASE: begin
                if (!ack_in) begin
                    done_nxt = 1'b1;
                    // Chain straight into the next request so the queued
                    // word does not pay an extra IDLE cycle.
                    if (pend_vld) begin
                        launch_pend = 1'b1;
                        state_nxt   = ST_REQ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // A send that cannot launch directly needs the slot. The slot counts as
    // free if it is empty or drains on this same edge.
    assign slot_free  = !pend_vld || launch_pend;
    assign store_send = send && !launch_direct && slot_free;
    assign drop_send  = send && !launch_direct && !slot_free;

    assign busy = (state != ST_IDLE) || pend_vld;

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values no matter what order the
        // statements appear in.
        if (rst) begin
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
            tmo_cnt  <= '0;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state <= state_nxt;

            // req_out is registered so the crossing sees a glitch-free level.
            req_out <= (state_nxt == ST_REQ);

            // data_out changes only on a launch edge, which is always an edge
            // where req_out goes from 0 to 1. It is never touched while a
            // request is up.
            if (launch_direct) begin
                data_out <= data_in;
            end else if (launch_pend) begin
                data_out <= pend_data;
            end

            if (store_send) begin
                pend_vld <= 1'b1;
            end else if (launch_pend) begin
                pend_vld <= 1'b0;
            end

            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (state != ST_IDLE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            done     <= done_nxt;
            overflow <= drop_send;
            timeout  <= tmo_hit;
        end
    end

    // -----------------------------------------------------------------------
    // Pending word storage
    // -----------------------------------------------------------------------
    // NOTE: the pending word is qualified by pend_vld, so it needs no reset.
    // Leaving datapath storage unreset keeps it out of the reset tree.
    always_ff @(posedge clk) begin
        if (store_send) begin
            pend_data <= data_in;
        end
    end

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    // The destination samples data_out while req_out is high, so the word
    // must not move under it.
    a_data_stable : assert property (@(posedge clk) disable iff (rst)
        (req_out && $past(req_out)) |-> $stable(data_out));

    // Completion and abandonment are mutually exclusive outcomes.
    a_done_xor_tmo : assert property (@(posedge clk) disable iff (rst)
        !(done && timeout));

endmodule

// File: tb/tb_ogfx_sync_req_tx.sv
// ---------------------------------------------------------------------------
// tb_ogfx_sync_req_tx
//
// Bench for ogfx_sync_req_tx (DW=16, TMO_W=4). Each word expected to
// reach the destination is queued when its send is driven. A monitor pops
// the queue on every rising edge of req_out and compares the word against
// data_out. The monitor also checks that data_out holds while req_out
// stays high. Cycle-exact checks cover done, overflow, timeout, busy and
// reset behaviour.
// ---------------------------------------------------------------------------
module tb_ogfx_sync_req_tx;

    localparam int DW    = 16;
    localparam int TMO_W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          send;
    logic [DW-1:0] data_in;
    logic          ack_in;
    logic          req_out;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          timeout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_q[$];
    logic          req_prev = 1'b0;
    logic [DW-1:0] hold_w   = '0;
    logic [DW-1:0] exp_w;

    ogfx_sync_req_tx #(.DW(DW), .TMO_W(TMO_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .data_in  (data_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle. Inputs set and outputs read after this call
    // belong to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic level, input string tag);
        int n = 0;
        while (req_out !== level && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(req_out), 32'(level));
    endtask

    // Complete one four-phase handshake and finish in the done cycle.
    task automatic handshake();
        wait_req(1'b1, "hs_req_up");
        ack_in = 1'b1;
        tick();
        wait_req(1'b0, "hs_req_down");
        ack_in = 1'b0;
        tick();
        check("hs_done", 32'(done), 32'(1));
    endtask

    // Scoreboard monitor: compare at the negedge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (req_out === 1'b1 && !req_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_req", 32'(exp_q.size()), 32'(1));
                end else begin
                    exp_w = exp_q.pop_front();
                    check("sb_data", 32'(data_out), 32'(exp_w));
                end
            end else if (req_out === 1'b1 && req_prev) begin
                check("data_hold", 32'(data_out), 32'(hold_w));
            end
            req_prev = (req_out === 1'b1);
            hold_w   = data_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        send    = 1'b0;
        data_in = '0;
        ack_in  = 1'b0;
        tick();
        tick();
        check("rst_req",      32'(req_out),  32'(0));
        check("rst_data",     32'(data_out), 32'(0));
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_done",     32'(done),     32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_timeout",  32'(timeout),  32'(0));
        rst = 1'b0;
        tick();

        // Single transfer: send at cycle 0, ack up at 4, down at 8.
        send    = 1'b1;
        data_in = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        tick();
        send = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("t1_req",  32'(req_out),  32'(c <= 4));
            check("t1_data", 32'(data_out), 32'hA5C3);
            check("t1_done", 32'(done),     32'(0));
            if (c == 4) ack_in = 1'b1;
            if (c == 8) ack_in = 1'b0;
            tick();
        end
        check("t1_done_pulse", 32'(done),    32'(1));
        check("t1_busy_end",   32'(busy),    32'(0));
        check("t1_req_end",    32'(req_out), 32'(0));
        tick();
        check("t1_done_once",  32'(done),    32'(0));

        // Back-to-back: second word queued while in REQ and chained at ack fall.
        send    = 1'b1;
        data_in = 16'h0001;
        exp_q.push_back(16'h0001);
        tick();
        send = 1'b0;
        tick();
        send    = 1'b1;
        data_in = 16'h0002;
        exp_q.push_back(16'h0002);
        tick();
        send   = 1'b0;
        ack_in = 1'b1;
        tick();
        check("t2_req_drop", 32'(req_out),  32'(0));
        check("t2_busy",     32'(busy),     32'(1));
        check("t2_data_kept", 32'(data_out), 32'h0001);
        ack_in = 1'b0;
        tick();
        check("t2_done",     32'(done),     32'(1));
        check("t2_req_again", 32'(req_out), 32'(1));
        check("t2_data2",    32'(data_out), 32'h0002);
        handshake();
        check("t2_busy_end", 32'(busy), 32'(0));
        tick();

        // Overflow: third send while the slot holds 0x0022 is dropped.
        send    = 1'b1;
        data_in = 16'h0011;
        exp_q.push_back(16'h0011);
        tick();
        data_in = 16'h0022;
        exp_q.push_back(16'h0022);
        tick();
        data_in = 16'h0033;
        tick();
        send = 1'b0;
        check("t3_overflow",      32'(overflow), 32'(1));
        tick();
        check("t3_overflow_once", 32'(overflow), 32'(0));
        handshake();
        check("t3_req_next",  32'(req_out),  32'(1));
        check("t3_data_next", 32'(data_out), 32'h0022);
        handshake();
        check("t3_busy_end", 32'(busy), 32'(0));
        tick();

        // Timeout: ack never comes; 15 cycles of REQ, then abandon.
        send    = 1'b1;
        data_in = 16'h0BAD;
        exp_q.push_back(16'h0BAD);
        tick();
        send = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            check("t4_req_held", 32'(req_out), 32'(1));
            check("t4_no_tmo",   32'(timeout), 32'(0));
            tick();
        end
        check("t4_timeout",   32'(timeout), 32'(1));
        check("t4_req_drop",  32'(req_out), 32'(0));
        check("t4_idle",      32'(busy),    32'(0));
        tick();
        check("t4_tmo_once",  32'(timeout), 32'(0));

        // Stale ack: send while ack is still high waits in the slot.
        ack_in = 1'b1;
        tick();
        send    = 1'b1;
        data_in = 16'h00FF;
        exp_q.push_back(16'h00FF);
        tick();
        send = 1'b0;
        check("t5_req_low",  32'(req_out), 32'(0));
        check("t5_busy",     32'(busy),    32'(1));
        tick();
        check("t5_req_low2", 32'(req_out), 32'(0));
        ack_in = 1'b0;
        tick();
        check("t5_req_up",   32'(req_out),  32'(1));
        check("t5_data",     32'(data_out), 32'h00FF);
        handshake();
        check("t5_busy_end", 32'(busy), 32'(0));
        tick();

        // Reset in RELEASE with a word pending: everything clears, no done.
        send    = 1'b1;
        data_in = 16'h1234;
        exp_q.push_back(16'h1234);
        tick();
        data_in = 16'h5678;
        tick();
        send   = 1'b0;
        ack_in = 1'b1;
        tick();
        check("t6_release", 32'(req_out), 32'(0));
        check("t6_busy",    32'(busy),    32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_req",  32'(req_out),  32'(0));
        check("t6_rst_busy", 32'(busy),     32'(0));
        check("t6_rst_done", 32'(done),     32'(0));
        check("t6_rst_data", 32'(data_out), 32'(0));
        ack_in = 1'b0;
        tick();
        check("t6_no_done",   32'(done),    32'(0));
        check("t6_no_launch", 32'(req_out), 32'(0));
        check("t6_pend_gone", 32'(busy),    32'(0));
        tick();
        check("t6_still_idle", 32'(req_out), 32'(0));

        tick();
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
